decoder_onehot_scan: RTL and testbench

//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with enable and a scan mode.

---
 rtl/decoder_onehot_scan_pkg.sv | 20 ++
 rtl/decoder_onehot_scan_if.sv | 26 ++
 rtl/decoder_onehot_scan_dwell_timer.sv | 50 +++++
 rtl/decoder_onehot_scan.sv | 98 +++++++++
 tb/tb_decoder_onehot_scan.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_onehot_scan_pkg.sv
// Shared definitions for the one-hot decoder family: mode encodings, width limits
// and a width-generic one-hot decode helper.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select supported by the decoder family; narrower users truncate the result.
    localparam int MAX_SEL_W = 6;
    localparam int MAX_N     = 64;

    // Decode a select value into a one-hot vector of MAX_N bits.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_N-1:0] vec;
        vec      = 64'd0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_onehot_scan_if.sv
// Control/status bundle for decoder_onehot_scan. The master drives the controls,
// the decoder (slave) returns the decoded strobes and its select state.
interface decoder_onehot_scan_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel_in;
    logic [N-1:0]     y;
    logic [SEL_W-1:0] sel_q;
    logic             wrap;

    modport master (
        output en, mode, load, sel_in,
        input  y, sel_q, wrap
    );

    modport slave (
        input  en, mode, load, sel_in,
        output y, sel_q, wrap
    );

endinterface

// File: rtl/decoder_onehot_scan_dwell_timer.sv
// Dwell counter: counts enabled cycles from 0 to DWELL-1 and flags the terminal
// count, wrapping back to 0 on the cycle after terminal count. clr has priority
// over hold, hold over counting.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    assign tc = (cnt_r == TC_VAL);

    // Next count: clear, freeze, advance or roll over at terminal count.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (hold) begin
            cnt_next_s = cnt_r;
        end else if (en) begin
            if (tc) begin
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/decoder_onehot_scan.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with enable, direct-load and scan
// modes. All outputs come straight from flops so strobes are glitch-free.
module decoder_onehot_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    decoder_onehot_scan_if.slave bus
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] Y_INACTIVE = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] sel_q_r;
    logic [N-1:0]     y_r;
    logic             wrap_r;

    logic [SEL_W-1:0] sel_next_s;
    logic [N-1:0]     y_dec_s;
    logic [N-1:0]     y_next_s;
    logic             wrap_next_s;
    logic             tmr_clr_s;
    logic             tmr_hold_s;
    logic             tmr_en_s;
    logic             tmr_tc_s;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .hold  (tmr_hold_s),
        .en    (tmr_en_s),
        .tc    (tmr_tc_s)
    );

    // Next-state priority: disable freezes, load beats scan, scan advances at dwell end.
    always_comb begin
        sel_next_s  = sel_q_r;
        wrap_next_s = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_hold_s  = 1'b0;
        tmr_en_s    = 1'b0;
        if (!bus.en) begin
            tmr_hold_s = 1'b1;
        end else if (bus.load) begin
            sel_next_s = bus.sel_in;
            tmr_clr_s  = 1'b1;
        end else if (bus.mode == MODE_SCAN) begin
            tmr_en_s = 1'b1;
            if (tmr_tc_s) begin
                sel_next_s  = sel_q_r + SEL_W'(1);
                wrap_next_s = (sel_q_r == SEL_LAST);
            end else begin
                sel_next_s  = sel_q_r;
                wrap_next_s = 1'b0;
            end
        end else begin
            tmr_clr_s = 1'b1;
        end
    end

    // Decode the next select, then apply output polarity or force inactive when disabled.
    always_comb begin
        y_dec_s = N'(onehot(MAX_SEL_W'(sel_next_s)));
        if (!bus.en) begin
            y_next_s = Y_INACTIVE;
        end else if (ACTIVE_LOW) begin
            y_next_s = ~y_dec_s;
        end else begin
            y_next_s = y_dec_s;
        end
    end

    // Select, strobe and wrap output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q_r <= {SEL_W{1'b0}};
            y_r     <= Y_INACTIVE;
            wrap_r  <= 1'b0;
        end else begin
            sel_q_r <= sel_next_s;
            y_r     <= y_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

    assign bus.sel_q = sel_q_r;
    assign bus.y     = y_r;
    assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Bench for decoder_onehot_scan: a main instance (SEL_W=3, DWELL=4), an active-low
// twin sharing its controls, and a SEL_W=1/DWELL=1 corner instance.
module tb_decoder_onehot_scan;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decoder_onehot_scan_if #(.SEL_W(3)) ifa ();
    decoder_onehot_scan_if #(.SEL_W(3)) ifb ();
    decoder_onehot_scan_if #(.SEL_W(1)) ifc ();

    assign ifb.en     = ifa.en;
    assign ifb.mode   = ifa.mode;
    assign ifb.load   = ifa.load;
    assign ifb.sel_in = ifa.sel_in;

    decoder_onehot_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    decoder_onehot_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    decoder_onehot_scan #(.SEL_W(1), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic [7:0] y;
        logic [2:0] sel;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model state for the main instance.
    logic [2:0] m_sel;
    int         m_cnt;
    logic       m_wrap;
    logic [7:0] m_y;

    task automatic model_reset();
        m_sel  = 3'd0;
        m_cnt  = 0;
        m_wrap = 1'b0;
        m_y    = 8'd0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic s_en, input logic s_mode, input logic s_load,
                        input logic [2:0] s_sel, input string tag);
        exp_t e;
        exp_t got;
        ifa.en     = s_en;
        ifa.mode   = s_mode;
        ifa.load   = s_load;
        ifa.sel_in = s_sel;
        if (!s_en) begin
            m_wrap = 1'b0;
        end else if (s_load) begin
            m_sel  = s_sel;
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else if (s_mode) begin
            if (m_cnt == 3) begin
                m_wrap = (m_sel == 3'd7);
                m_sel  = m_sel + 3'd1;
                m_cnt  = 0;
            end else begin
                m_cnt  = m_cnt + 1;
                m_wrap = 1'b0;
            end
        end else begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end
        m_y    = s_en ? (8'd1 << m_sel) : 8'd0;
        e.y    = m_y;
        e.sel  = m_sel;
        e.wrap = m_wrap;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        total++;
        if (ifa.y !== got.y) begin
            bad++;
            $display("FAIL %s y: got %h want %h", tag, ifa.y, got.y);
        end
        total++;
        if (ifa.sel_q !== got.sel) begin
            bad++;
            $display("FAIL %s sel_q: got %0d want %0d", tag, ifa.sel_q, got.sel);
        end
        total++;
        if (ifa.wrap !== got.wrap) begin
            bad++;
            $display("FAIL %s wrap: got %b want %b", tag, ifa.wrap, got.wrap);
        end
        total++;
        if (ifb.y !== ~got.y) begin
            bad++;
            $display("FAIL %s y_active_low: got %h want %h", tag, ifb.y, ~got.y);
        end
    endtask

    task automatic test_reset();
        ifa.en = 1'b0; ifa.mode = 1'b0; ifa.load = 1'b0; ifa.sel_in = 3'd0;
        ifc.en = 1'b0; ifc.mode = 1'b0; ifc.load = 1'b0; ifc.sel_in = 1'b0;
        rst_n = 1'b0;
        #12;
        total++;
        if (ifa.y !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", ifa.y); end
        total++;
        if (ifa.sel_q !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", ifa.sel_q); end
        total++;
        if (ifa.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", ifa.wrap); end
        total++;
        if (ifb.y !== 8'hFF) begin bad++; $display("FAIL reset_y_al: got %h want ff", ifb.y); end
        total++;
        if (ifc.y !== 2'b00) begin bad++; $display("FAIL reset_y_c: got %b want 00", ifc.y); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_direct();
        logic [7:0] exp_y;
        step(1'b1, 1'b0, 1'b1, 3'd5, "direct_load5");
        total++;
        if (ifa.y !== 8'h20) begin bad++; $display("FAIL direct_y5: got %h want 20", ifa.y); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 3'd2, "direct_hold");
        end
        total++;
        if (ifa.y !== 8'h20) begin bad++; $display("FAIL direct_hold_y: got %h want 20", ifa.y); end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'(i), "direct_sweep");
            exp_y = 8'd1 << i;
            total++;
            if (ifa.y !== exp_y) begin
                bad++;
                $display("FAIL direct_sweep_%0d: got %h want %h", i, ifa.y, exp_y);
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_y;
        int         wraps;
        wraps = 0;
        step(1'b1, 1'b0, 1'b1, 3'd0, "scan_load0");
        for (int c = 1; c <= 36; c++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, "scan");
            exp_y = 8'd1 << ((c / 4) % 8);
            total++;
            if (ifa.y !== exp_y) begin
                bad++;
                $display("FAIL scan_y_c%0d: got %h want %h", c, ifa.y, exp_y);
            end
            if (ifa.wrap === 1'b1) begin
                wraps++;
                total++;
                if (c != 32 || ifa.y !== 8'h01) begin
                    bad++;
                    $display("FAIL scan_wrap_pos: got cycle %0d y %h want cycle 32 y 01", c, ifa.y);
                end
            end
        end
        total++;
        if (wraps != 1) begin bad++; $display("FAIL scan_wrap_count: got %0d want 1", wraps); end
    endtask

    task automatic test_enable();
        step(1'b1, 1'b1, 1'b1, 3'd3, "en_load3");
        step(1'b1, 1'b1, 1'b0, 3'd0, "en_scan1");
        step(1'b1, 1'b1, 1'b0, 3'd0, "en_scan2");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 3'd0, "en_off");
            total++;
            if (ifa.y !== 8'h00) begin bad++; $display("FAIL en_off_y: got %h want 00", ifa.y); end
        end
        step(1'b1, 1'b1, 1'b0, 3'd0, "en_resume");
        total++;
        if (ifa.y !== 8'h08) begin bad++; $display("FAIL en_resume_y: got %h want 08", ifa.y); end
        step(1'b1, 1'b1, 1'b0, 3'd0, "en_advance");
        total++;
        if (ifa.y !== 8'h10) begin bad++; $display("FAIL en_advance_y: got %h want 10", ifa.y); end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 1'b1, 3'd7, "col_load7");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, "col_scan");
        end
        step(1'b1, 1'b1, 1'b1, 3'd6, "col_load6");
        total++;
        if (ifa.y !== 8'h40 || ifa.wrap !== 1'b0) begin
            bad++;
            $display("FAIL collision: got y %h wrap %b want y 40 wrap 0", ifa.y, ifa.wrap);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, "col_dwell");
        end
        total++;
        if (ifa.y !== 8'h40) begin bad++; $display("FAIL col_dwell_y: got %h want 40", ifa.y); end
        step(1'b1, 1'b1, 1'b0, 3'd0, "col_next");
        total++;
        if (ifa.y !== 8'h80) begin bad++; $display("FAIL col_next_y: got %h want 80", ifa.y); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 1'b1, 3'd2, "ar_load2");
        step(1'b1, 1'b1, 1'b0, 3'd0, "ar_scan");
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ifa.y !== 8'h00 || ifa.sel_q !== 3'd0) begin
            bad++;
            $display("FAIL async_reset: got y %h sel %0d want y 00 sel 0", ifa.y, ifa.sel_q);
        end
        total++;
        if (ifb.y !== 8'hFF) begin bad++; $display("FAIL async_reset_al: got %h want ff", ifb.y); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b1, 1'b0, 3'd0, "ar_restart");
        total++;
        if (ifa.y !== 8'h01) begin bad++; $display("FAIL ar_restart_y: got %h want 01", ifa.y); end
    endtask

    task automatic test_corner();
        logic [1:0] exp_y;
        logic       exp_wrap;
        ifa.en = 1'b0;
        ifc.en = 1'b1; ifc.mode = 1'b1; ifc.load = 1'b0; ifc.sel_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_y    = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_wrap = (k % 2 == 0);
            total++;
            if (ifc.y !== exp_y || ifc.wrap !== exp_wrap) begin
                bad++;
                $display("FAIL corner_k%0d: got y %b wrap %b want y %b wrap %b",
                         k, ifc.y, ifc.wrap, exp_y, exp_wrap);
            end
        end
        ifc.en = 1'b0;
    endtask

    task automatic test_random();
        logic r_en;
        logic r_mode;
        logic r_load;
        for (int i = 0; i < 200; i++) begin
            r_en   = ($urandom_range(0, 3) != 0);
            r_mode = 1'($urandom_range(0, 1));
            r_load = ($urandom_range(0, 3) == 0);
            step(r_en, r_mode, r_load, 3'($urandom_range(0, 7)), "random");
            total++;
            if (r_en ? ($countones(ifa.y) != 1) : (ifa.y !== 8'h00)) begin
                bad++;
                $display("FAIL onehot_invariant: got y %h en %b want exactly one bit when enabled",
                         ifa.y, r_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_enable();
        test_collision();
        test_async_reset();
        test_corner();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
